// File: rtl/rs_age_issue.sv
// rs_age_issue: reservation station with CDB wakeup, age-matrix oldest-first issue and ROB squash.
// Build option RS_CDB_BYPASS_EN: operands matched on the CDB this cycle count as ready and issue the CDB value.
module rs_age_issue #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned DISP_W    = 3,
  parameter int unsigned CDB_W     = 3,
  parameter int unsigned NUM_CLASS = 4,
  parameter int unsigned ISSUE_W   = 2,
  parameter int unsigned PRN_W     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned PAYLOAD_W = 64,
  localparam int unsigned CLS_W    = $clog2(NUM_CLASS),
  localparam int unsigned CNT_W    = $clog2(SIZE + 1),
  localparam int unsigned IDX_W    = $clog2(SIZE)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [DISP_W-1:0]                             disp_valid,
  input  logic [DISP_W-1:0][CLS_W-1:0]                  disp_class,
  input  logic [DISP_W-1:0]                             disp_op1_rdy,
  input  logic [DISP_W-1:0][DATA_W-1:0]                 disp_op1,
  input  logic [DISP_W-1:0]                             disp_op2_rdy,
  input  logic [DISP_W-1:0][DATA_W-1:0]                 disp_op2,
  input  logic [DISP_W-1:0][PRN_W-1:0]                  disp_dest_prn,
  input  logic [DISP_W-1:0][ROB_W-1:0]                  disp_robn,
  input  logic [DISP_W-1:0][PAYLOAD_W-1:0]              disp_payload,
  input  logic [CDB_W-1:0][PRN_W-1:0]                   cdb_prn,
  input  logic [CDB_W-1:0][DATA_W-1:0]                  cdb_value,
  input  logic [NUM_CLASS-1:0][ISSUE_W-1:0]             fu_avail,
  input  logic                                          squash_valid,
  input  logic [ROB_W-1:0]                              squash_robn,
  input  logic [ROB_W-1:0]                              rob_head,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0]             iss_valid,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0][DATA_W-1:0] iss_op1,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0][DATA_W-1:0] iss_op2,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0][PRN_W-1:0]  iss_dest_prn,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0][ROB_W-1:0]  iss_robn,
  output logic [NUM_CLASS-1:0][ISSUE_W-1:0][PAYLOAD_W-1:0] iss_payload,
  output logic                                          almost_full,
  output logic [CNT_W-1:0]                              count
);

  logic [SIZE-1:0]      valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [CLS_W-1:0]     cls_q  [SIZE];
  logic [CLS_W-1:0]     cls_d  [SIZE];
  logic [DATA_W-1:0]    op1_q  [SIZE];
  logic [DATA_W-1:0]    op1_d  [SIZE];
  logic [DATA_W-1:0]    op2_q  [SIZE];
  logic [DATA_W-1:0]    op2_d  [SIZE];
  logic [PRN_W-1:0]     dest_q [SIZE];
  logic [PRN_W-1:0]     dest_d [SIZE];
  logic [ROB_W-1:0]     robn_q [SIZE];
  logic [ROB_W-1:0]     robn_d [SIZE];
  logic [PAYLOAD_W-1:0] pay_q  [SIZE];
  logic [PAYLOAD_W-1:0] pay_d  [SIZE];
  logic [SIZE-1:0]      age_q  [SIZE];  // age_q[j][i]: entry j is older than entry i
  logic [SIZE-1:0]      age_d  [SIZE];
  logic [CNT_W-1:0]     count_d;

  logic [SIZE-1:0]      wrdy1, wrdy2, dead, ready, grant, taken;
  logic [DATA_W-1:0]    wop1 [SIZE];
  logic [DATA_W-1:0]    wop2 [SIZE];
  logic [DATA_W-1:0]    iv1  [SIZE];
  logic [DATA_W-1:0]    iv2  [SIZE];
  logic [IDX_W-1:0]     rank [SIZE];
  logic [IDX_W-1:0]     slot;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0] sel_v;
  logic [IDX_W-1:0]     sel_idx [NUM_CLASS][ISSUE_W];
  logic [DISP_W-1:0]    accept;
  logic                 placed;

  // Operand capture from the CDB; the lowest matching port wins.
  function automatic logic [DATA_W:0] wake(input logic rdy, input logic [DATA_W-1:0] val,
                                           input logic [CDB_W-1:0][PRN_W-1:0] prn,
                                           input logic [CDB_W-1:0][DATA_W-1:0] cv);
    logic [DATA_W:0] r;
    r = {rdy, val};
    if (!rdy) begin
      for (int k = int'(CDB_W) - 1; k >= 0; k--) begin
        if (prn[k] != '0 && prn[k] == PRN_W'(val)) r = {1'b1, cv[k]};
      end
    end
    return r;
  endfunction

  // Per-entry wakeup, squash kill and issue readiness.
  always_comb begin
    for (int i = 0; i < int'(SIZE); i++) begin
      {wrdy1[i], wop1[i]} = wake(rdy1_q[i], op1_q[i], cdb_prn, cdb_value);
      {wrdy2[i], wop2[i]} = wake(rdy2_q[i], op2_q[i], cdb_prn, cdb_value);
      dead[i] = valid_q[i] & squash_valid &
                (ROB_W'(robn_q[i] - rob_head) > ROB_W'(squash_robn - rob_head));
`ifdef RS_CDB_BYPASS_EN
      ready[i] = valid_q[i] & ~dead[i] & wrdy1[i] & wrdy2[i];
      iv1[i]   = wop1[i];
      iv2[i]   = wop2[i];
`else
      ready[i] = valid_q[i] & ~dead[i] & rdy1_q[i] & rdy2_q[i];
      iv1[i]   = op1_q[i];
      iv2[i]   = op2_q[i];
`endif
    end
  end

  // Rank = number of older ready ops of the same class; the k-th available port takes rank k.
  always_comb begin
    grant = '0;
    sel_v = '0;
    slot  = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      rank[i] = '0;
      for (int j = 0; j < int'(SIZE); j++) begin
        if (ready[j] && cls_q[j] == cls_q[i] && age_q[j][i]) rank[i] = rank[i] + IDX_W'(1);
      end
    end
    for (int c = 0; c < int'(NUM_CLASS); c++) begin
      for (int p = 0; p < int'(ISSUE_W); p++) begin
        sel_idx[c][p] = '0;
        slot = '0;
        for (int q = 0; q < p; q++) begin
          if (fu_avail[c][q]) slot = slot + IDX_W'(1);
        end
        for (int i = 0; i < int'(SIZE); i++) begin
          if (fu_avail[c][p] && ready[i] && cls_q[i] == CLS_W'(c) && rank[i] == slot) begin
            sel_v[c][p]   = 1'b1;
            sel_idx[c][p] = IDX_W'(i);
            grant[i]      = 1'b1;
          end
        end
      end
    end
  end

  // Entry update: free issued/dead entries, wake operands, allocate accepted lanes.
  always_comb begin
    valid_d = valid_q & ~grant & ~dead;
    rdy1_d  = wrdy1;
    rdy2_d  = wrdy2;
    op1_d   = wop1;
    op2_d   = wop2;
    cls_d   = cls_q;
    dest_d  = dest_q;
    robn_d  = robn_q;
    pay_d   = pay_q;
    age_d   = age_q;
    taken   = valid_q;
    placed  = 1'b0;
    count_d = '0;
    accept  = disp_valid & {DISP_W{~almost_full & ~squash_valid}};
    for (int i = 0; i < int'(SIZE); i++) begin
      if (valid_q[i] && !valid_d[i]) begin
        for (int j = 0; j < int'(SIZE); j++) age_d[j][i] = 1'b0;
      end
    end
    for (int l = 0; l < int'(DISP_W); l++) begin
      placed = 1'b0;
      for (int i = 0; i < int'(SIZE); i++) begin
        if (accept[l] && !placed && !taken[i]) begin
          placed   = 1'b1;
          taken[i] = 1'b1;
          {rdy1_d[i], op1_d[i]} = wake(disp_op1_rdy[l], disp_op1[l], cdb_prn, cdb_value);
          {rdy2_d[i], op2_d[i]} = wake(disp_op2_rdy[l], disp_op2[l], cdb_prn, cdb_value);
          cls_d[i]  = disp_class[l];
          dest_d[i] = disp_dest_prn[l];
          robn_d[i] = disp_robn[l];
          pay_d[i]  = disp_payload[l];
          age_d[i]  = '0;
          for (int j = 0; j < int'(SIZE); j++) age_d[j][i] = valid_d[j];
          valid_d[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(SIZE); i++) count_d = count_d + CNT_W'(valid_d[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      count        <= '0;
      almost_full  <= 1'b0;
      iss_valid    <= '0;
      iss_op1      <= '0;
      iss_op2      <= '0;
      iss_dest_prn <= '0;
      iss_robn     <= '0;
      iss_payload  <= '0;
      for (int i = 0; i < int'(SIZE); i++) age_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      age_q       <= age_d;
      count       <= count_d;
      almost_full <= (count_d > CNT_W'(SIZE - DISP_W));
      iss_valid   <= sel_v;
      for (int c = 0; c < int'(NUM_CLASS); c++) begin
        for (int p = 0; p < int'(ISSUE_W); p++) begin
          if (sel_v[c][p]) begin
            iss_op1[c][p]      <= iv1[sel_idx[c][p]];
            iss_op2[c][p]      <= iv2[sel_idx[c][p]];
            iss_dest_prn[c][p] <= dest_q[sel_idx[c][p]];
            iss_robn[c][p]     <= robn_q[sel_idx[c][p]];
            iss_payload[c][p]  <= pay_q[sel_idx[c][p]];
          end
        end
      end
    end
  end

  // Entry payload storage; qualified by valid_q, so no reset needed.
  always_ff @(posedge clock) begin
    rdy1_q <= rdy1_d;
    rdy2_q <= rdy2_d;
    op1_q  <= op1_d;
    op2_q  <= op2_d;
    cls_q  <= cls_d;
    dest_q <= dest_d;
    robn_q <= robn_d;
    pay_q  <= pay_d;
  end

endmodule

// File: tb/tb_rs_age_issue.sv
// tb_rs_age_issue: directed scenarios plus random traffic against an age-ordered queue model.
// Follows RS_CDB_BYPASS_EN the same way as the design.
module tb_rs_age_issue;
  localparam int unsigned SIZE = 16, DISP_W = 3, CDB_W = 3, NUM_CLASS = 4, ISSUE_W = 2;
  localparam int unsigned PRN_W = 6, DATA_W = 32, ROB_W = 5, PAYLOAD_W = 64;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [DISP_W-1:0]                 disp_valid, disp_op1_rdy, disp_op2_rdy;
  logic [DISP_W-1:0][1:0]            disp_class;
  logic [DISP_W-1:0][DATA_W-1:0]     disp_op1, disp_op2;
  logic [DISP_W-1:0][PRN_W-1:0]      disp_dest_prn;
  logic [DISP_W-1:0][ROB_W-1:0]      disp_robn;
  logic [DISP_W-1:0][PAYLOAD_W-1:0]  disp_payload;
  logic [CDB_W-1:0][PRN_W-1:0]       cdb_prn;
  logic [CDB_W-1:0][DATA_W-1:0]      cdb_value;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0] fu_avail, iss_valid;
  logic                              squash_valid, almost_full;
  logic [ROB_W-1:0]                  squash_robn, rob_head;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0][DATA_W-1:0]    iss_op1, iss_op2;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0][PRN_W-1:0]     iss_dest_prn;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0][ROB_W-1:0]     iss_robn;
  logic [NUM_CLASS-1:0][ISSUE_W-1:0][PAYLOAD_W-1:0] iss_payload;
  logic [4:0]                        count;

  always #5 clock = ~clock;

  rs_age_issue dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_class(disp_class),
    .disp_op1_rdy(disp_op1_rdy), .disp_op1(disp_op1),
    .disp_op2_rdy(disp_op2_rdy), .disp_op2(disp_op2),
    .disp_dest_prn(disp_dest_prn), .disp_robn(disp_robn), .disp_payload(disp_payload),
    .cdb_prn(cdb_prn), .cdb_value(cdb_value), .fu_avail(fu_avail),
    .squash_valid(squash_valid), .squash_robn(squash_robn), .rob_head(rob_head),
    .iss_valid(iss_valid), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_dest_prn(iss_dest_prn), .iss_robn(iss_robn), .iss_payload(iss_payload),
    .almost_full(almost_full), .count(count)
  );

  // Model entry; the queue holding them is kept oldest-first.
  typedef struct {
    int          cls;
    bit          r1;
    logic [31:0] v1;
    bit          r2;
    logic [31:0] v2;
    logic [5:0]  dest;
    logic [4:0]  robn;
    logic [63:0] pay;
  } ment_t;
  typedef struct { logic [7:0] mask; int cnt; bit af; bit zchk; } ecyc_t;
  typedef struct { logic [31:0] op1; logic [31:0] op2; logic [5:0] dest; logic [4:0] robn; logic [63:0] pay; } eiss_t;

  ment_t mq[$];
  ecyc_t exp_cyc[$];
  eiss_t exp_iss[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cdb_find(input logic [5:0] tag, output logic [31:0] val);
    bit hit;
    hit = 1'b0;
    val = '0;
    for (int k = 0; k < int'(CDB_W); k++) begin
      if (!hit && cdb_prn[k] != 0 && cdb_prn[k] == tag) begin
        hit = 1'b1;
        val = cdb_value[k];
      end
    end
    return hit;
  endfunction

  // Predict what the coming clock edge produces from the current inputs.
  task automatic model_step();
    ment_t m;
    ment_t nq[$];
    ecyc_t ec;
    bit kill[32];
    bit iss[32];
    bit rdy[32];
    logic [31:0] o1[32];
    logic [31:0] o2[32];
    logic [31:0] cv;
    logic [4:0] ea, sa;
    logic [7:0] mask;
    bit r1, r2, af;
    int n, k;
    int lst[$];
    if (reset) begin
      mq.delete();
      ec = '{8'h00, 0, 1'b0, 1'b1};
      exp_cyc.push_back(ec);
      return;
    end
    n  = mq.size();
    af = n > int'(SIZE - DISP_W);
    sa = squash_robn - rob_head;
    for (int e = 0; e < n; e++) begin
      ea = mq[e].robn - rob_head;
      kill[e] = squash_valid && (ea > sa);
      iss[e]  = 1'b0;
      o1[e] = mq[e].v1;
      o2[e] = mq[e].v2;
      r1 = mq[e].r1;
      r2 = mq[e].r2;
      if (BYPASS && !r1 && cdb_find(o1[e][5:0], cv)) begin r1 = 1'b1; o1[e] = cv; end
      if (BYPASS && !r2 && cdb_find(o2[e][5:0], cv)) begin r2 = 1'b1; o2[e] = cv; end
      rdy[e] = !kill[e] && r1 && r2;
    end
    mask = '0;
    for (int c = 0; c < int'(NUM_CLASS); c++) begin
      lst.delete();
      for (int e = 0; e < n; e++) if (rdy[e] && mq[e].cls == c) lst.push_back(e);
      k = 0;
      for (int p = 0; p < int'(ISSUE_W); p++) begin
        if (fu_avail[c][p] && k < lst.size()) begin
          iss[lst[k]] = 1'b1;
          mask[c*ISSUE_W+p] = 1'b1;
          exp_iss.push_back('{o1[lst[k]], o2[lst[k]], mq[lst[k]].dest, mq[lst[k]].robn, mq[lst[k]].pay});
          k++;
        end
      end
    end
    for (int e = 0; e < n; e++) begin
      if (!kill[e] && !iss[e]) begin
        m = mq[e];
        if (!m.r1 && cdb_find(m.v1[5:0], cv)) begin m.r1 = 1'b1; m.v1 = cv; end
        if (!m.r2 && cdb_find(m.v2[5:0], cv)) begin m.r2 = 1'b1; m.v2 = cv; end
        nq.push_back(m);
      end
    end
    if (!af && !squash_valid) begin
      for (int l = 0; l < int'(DISP_W); l++) begin
        if (disp_valid[l]) begin
          m = '{int'(disp_class[l]), disp_op1_rdy[l], disp_op1[l], disp_op2_rdy[l], disp_op2[l],
                disp_dest_prn[l], disp_robn[l], disp_payload[l]};
          if (!m.r1 && cdb_find(m.v1[5:0], cv)) begin m.r1 = 1'b1; m.v1 = cv; end
          if (!m.r2 && cdb_find(m.v2[5:0], cv)) begin m.r2 = 1'b1; m.v2 = cv; end
          nq.push_back(m);
        end
      end
    end
    mq = nq;
    ec = '{mask, nq.size(), nq.size() > int'(SIZE - DISP_W), 1'b0};
    exp_cyc.push_back(ec);
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    disp_valid   = '0;
    cdb_prn      = '0;
    squash_valid = 1'b0;
  endtask

  task automatic set_lane(input int l, input int cls, input bit r1, input logic [31:0] v1,
                          input bit r2, input logic [31:0] v2, input logic [4:0] robn);
    disp_valid[l]    = 1'b1;
    disp_class[l]    = 2'(cls);
    disp_op1_rdy[l]  = r1;
    disp_op1[l]      = v1;
    disp_op2_rdy[l]  = r2;
    disp_op2[l]      = v2;
    disp_dest_prn[l] = 6'($urandom);
    disp_robn[l]     = robn;
    disp_payload[l]  = {$urandom, $urandom};
  endtask

  task automatic fill_waiting(input int lanes, input logic [5:0] tag);
    for (int l = 0; l < lanes; l++)
      set_lane(l, $urandom_range(0, 3), 1'b0, 32'(tag), 1'b0, 32'(tag), 5'($urandom));
    tick();
  endtask

  // Scoreboard monitor: one expectation record per clock edge.
  initial begin : monitor
    ecyc_t ec;
    eiss_t ei;
    forever begin
      @(posedge clock);
      #1;
      if (exp_cyc.size() != 0) begin
        ec = exp_cyc.pop_front();
        chk("iss_valid", 64'(iss_valid), 64'(ec.mask));
        chk("count", 64'(count), 64'(ec.cnt));
        chk("almost_full", 64'(almost_full), 64'(ec.af));
        if (ec.zchk)
          chk("reset_iss_data", 64'(|{iss_op1, iss_op2, iss_dest_prn, iss_robn, iss_payload}), 64'd0);
        for (int c = 0; c < int'(NUM_CLASS); c++) begin
          for (int p = 0; p < int'(ISSUE_W); p++) begin
            if (ec.mask[c*ISSUE_W+p]) begin
              if (exp_iss.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL iss_queue: no expected data for port %0d.%0d at %0t", c, p, $time);
              end else begin
                ei = exp_iss.pop_front();
                chk($sformatf("op1[%0d][%0d]", c, p), 64'(iss_op1[c][p]), 64'(ei.op1));
                chk($sformatf("op2[%0d][%0d]", c, p), 64'(iss_op2[c][p]), 64'(ei.op2));
                chk($sformatf("dest[%0d][%0d]", c, p), 64'(iss_dest_prn[c][p]), 64'(ei.dest));
                chk($sformatf("robn[%0d][%0d]", c, p), 64'(iss_robn[c][p]), 64'(ei.robn));
                chk($sformatf("payload[%0d][%0d]", c, p), iss_payload[c][p], ei.pay);
              end
            end
          end
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    disp_valid = '0; disp_class = '0; disp_op1_rdy = '0; disp_op1 = '0;
    disp_op2_rdy = '0; disp_op2 = '0; disp_dest_prn = '0; disp_robn = '0; disp_payload = '0;
    cdb_prn = '0; cdb_value = '0; fu_avail = '0;
    squash_valid = 1'b0; squash_robn = '0; rob_head = '0;
    tick(); tick();
    reset = 1'b0;

    // Three ready ALU ops: two issue, then the third
    fu_avail = '1;
    set_lane(0, 0, 1'b1, 32'h11, 1'b1, 32'h12, 5'd0);
    set_lane(1, 0, 1'b1, 32'h21, 1'b1, 32'h22, 5'd1);
    set_lane(2, 0, 1'b1, 32'h31, 1'b1, 32'h32, 5'd2);
    repeat (4) tick();

    // Wakeup on PRN 9; a tag-0 waiter must stay asleep under an idle CDB
    set_lane(0, 0, 1'b0, 32'd9, 1'b1, 32'h77, 5'd3);
    set_lane(1, 1, 1'b1, 32'h66, 1'b0, 32'd0, 5'd4);
    tick();
    cdb_prn[0] = 6'd9; cdb_value[0] = 32'h55; cdb_value[1] = 32'hAA;
    tick();
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;

    // Fill to full with waiting ops, then overflow attempts
    repeat (4) fill_waiting(3, 6'd20);
    fill_waiting(1, 6'd20);
    repeat (4) fill_waiting(3, 6'd20);
    cdb_prn[1] = 6'd20; cdb_value[1] = 32'hC0DE;
    tick();
    repeat (10) tick();

    // Squash around a wrapped ROB head
    fu_avail = '0; rob_head = 5'd28;
    set_lane(0, 2, 1'b1, 32'hA0, 1'b1, 32'hA1, 5'd30);
    set_lane(1, 2, 1'b1, 32'hB0, 1'b1, 32'hB1, 5'd1);
    set_lane(2, 3, 1'b1, 32'hC0, 1'b1, 32'hC1, 5'd3);
    tick();
    squash_valid = 1'b1; squash_robn = 5'd1;
    set_lane(0, 2, 1'b1, 32'hD0, 1'b1, 32'hD1, 5'd29);
    tick();
    fu_avail = '1;
    repeat (3) tick();
    rob_head = '0;

    // Oldest MULT goes to the only available MULT port
    fu_avail = '0;
    set_lane(0, 1, 1'b1, 32'hAAA0, 1'b1, 32'hAAA1, 5'd5);
    set_lane(1, 1, 1'b1, 32'hBBB0, 1'b1, 32'hBBB1, 5'd6);
    tick();
    fu_avail[1] = 2'b10;
    tick(); tick();
    fu_avail = '1;
    tick();

    // Dispatch at count SIZE-DISP_W while an entry issues
    fu_avail = '0;
    set_lane(0, 0, 1'b1, 32'h1234, 1'b1, 32'h5678, 5'd7);
    set_lane(1, 1, 1'b0, 32'd21, 1'b1, 32'h1, 5'd8);
    set_lane(2, 2, 1'b0, 32'd21, 1'b1, 32'h2, 5'd9);
    tick();
    repeat (3) fill_waiting(3, 6'd21);
    fill_waiting(1, 6'd21);
    fu_avail = '1;
    fill_waiting(3, 6'd21);
    cdb_prn[2] = 6'd21; cdb_value[2] = 32'hFEED;
    tick();
    repeat (10) tick();

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      for (int l = 0; l < int'(DISP_W); l++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_lane(l, $urandom_range(0, 3),
                   $urandom_range(0, 2) != 0, 32'($urandom_range(1, 7)),
                   $urandom_range(0, 2) != 0, 32'($urandom_range(1, 7)), 5'($urandom));
          if (disp_op1_rdy[l]) disp_op1[l] = $urandom;
          if (disp_op2_rdy[l]) disp_op2[l] = $urandom;
        end
      end
      for (int k = 0; k < int'(CDB_W); k++) begin
        cdb_prn[k]   = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 7)) : 6'd0;
        cdb_value[k] = $urandom;
      end
      fu_avail     = 8'($urandom);
      rob_head     = 5'($urandom);
      squash_robn  = 5'($urandom);
      squash_valid = ($urandom_range(0, 19) == 0);
      tick();
    end

    // Drain: every tag broadcast, all ports open
    fu_avail = '1;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < int'(CDB_W); k++) begin
        cdb_prn[k]   = 6'(((n * 3 + k) % 7) + 1);
        cdb_value[k] = $urandom;
      end
      tick();
    end
    repeat (3) tick();

    chk("exp_cyc_left", 64'(exp_cyc.size()), 64'd0);
    chk("exp_iss_left", 64'(exp_iss.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
